axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 171 +++++++++++++++++
 tb/tb_axi_sram_slave.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-outstanding AXI slave in front of a 2^MEM_AW x 32-bit SRAM
//   clk, rst                      : rising-edge clock, synchronous active-high reset
//   ar*/arready                   : read address channel (arsize ignored, full words assumed)
//   r*/rready                     : read data channel, first beat LATENCY+1 cycles after AR
//   aw*/awready                   : write address channel (awsize ignored)
//   w*/wready                     : write data channel with byte strobes (wid, wlast ignored)
//   b*/bready                     : write response channel
//   Optional macro AXI_SLAVE_DECERR_EN: out-of-range accesses answer DECERR instead of wrapping.
module axi_sram_slave #(
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1fc0_0000,
    parameter int          LATENCY   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;
    state_t state_q, state_d;
    logic [31:0] addr_q, addr_d, addr_nxt;
    logic [3:0] id_q, id_d;
    logic [7:0] len_q, len_d, cnt_q, cnt_d;
    logic [1:0] burst_q, burst_d;
    logic [2:0] wait_q, wait_d;
    logic err_q, err_d, arready_q;
    logic ar_oor, aw_oor, we, unused;
    logic [MEM_AW-1:0] idx;
    logic [31:0] mem [2**MEM_AW];

`ifdef AXI_SLAVE_DECERR_EN
    localparam logic [32:0] SPAN = 33'd1 << (MEM_AW + 2);
    // Offset is taken modulo 2^32 so addresses below BASE_ADDR land far above SPAN.
    assign ar_oor = {1'b0, araddr - BASE_ADDR} >= SPAN;
    assign aw_oor = {1'b0, awaddr - BASE_ADDR} >= SPAN;
`else
    assign ar_oor = 1'b0;
    assign aw_oor = 1'b0;
`endif

    assign idx      = MEM_AW'((addr_q - BASE_ADDR) >> 2);
    assign addr_nxt = burst_q == 2'b01 ? addr_q + 32'd4 : addr_q;
    // arready is registered so it stays low on the cycle right after reset.
    assign arready  = arready_q;
    assign awready  = arready_q & ~arvalid;
    assign wready   = state_q == WR_DATA;
    assign rvalid   = state_q == RD_DATA;
    assign bvalid   = state_q == WR_RESP;
    assign rid      = rvalid ? id_q : 4'd0;
    assign rdata    = rvalid && !err_q ? mem[idx] : 32'd0;
    assign rresp    = rvalid && err_q ? 2'b11 : 2'b00;
    assign rlast    = rvalid && cnt_q == len_q;
    assign bid      = bvalid ? id_q : 4'd0;
    assign bresp    = bvalid && err_q ? 2'b11 : 2'b00;
    assign we       = wready && wvalid && !err_q && !rst;
    assign unused   = ^{arsize, awsize, wid, wlast};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (arvalid && arready_q) begin
                    id_d    = arid;
                    addr_d  = araddr;
                    len_d   = arlen;
                    burst_d = arburst;
                    cnt_d   = 8'd0;
                    wait_d  = 3'(LATENCY);
                    err_d   = ar_oor;
                    state_d = LATENCY == 0 ? RD_DATA : RD_WAIT;
                end else if (awvalid && awready) begin
                    id_d    = awid;
                    addr_d  = awaddr;
                    len_d   = {4'd0, awlen};
                    burst_d = awburst;
                    cnt_d   = 8'd0;
                    err_d   = aw_oor;
                    state_d = WR_DATA;
                end
            end
            RD_WAIT: begin
                wait_d = wait_q - 3'd1;
                if (wait_q == 3'd1) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rready) begin
                    addr_d = addr_nxt;
                    cnt_d  = cnt_q + 8'd1;
                    if (rlast) state_d = IDLE;
                end
            end
            WR_DATA: begin
                if (wvalid) begin
                    addr_d = addr_nxt;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == len_q) state_d = WR_RESP;
                end
            end
            WR_RESP: if (bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= 32'd0;
            id_q      <= 4'd0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            burst_q   <= 2'd0;
            wait_q    <= 3'd0;
            err_q     <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            arready_q <= state_d == IDLE;
        end
    end

    // Memory is deliberately outside the reset domain; contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed vector bench for axi_sram_slave with LATENCY=2
module tb_axi_sram_slave;
    logic        clk = 1'b0, rst;
    logic [3:0]  arid, awid, wid, rid, bid, awlen, wstrb;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;
    int total = 0, passed = 0;

`ifdef AXI_SLAVE_DECERR_EN
    localparam bit DE = 1'b1;
`else
    localparam bit DE = 1'b0;
`endif

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } vec_t;
    localparam int NV = 17;
    vec_t tbl [NV];

    axi_sram_slave #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] outs();
        return 32'({arready, awready, wready, rvalid, bvalid, rlast, rresp, bresp, rid, bid});
    endfunction

    task automatic write_tail(input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
        int n;
        wdata = d; wstrb = s; wlast = 1'b0; wvalid = 1'b1;
        n = 0;
        while (!wready && n < 20) begin @(negedge clk); n++; end
        check("w_ready", 32'(wready), 32'd1);
        @(negedge clk);
        wvalid = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        check("b_valid", 32'(bvalid), 32'd1);
        check("b_resp", 32'(bresp), 32'(er));
        check("b_id", 32'(bid), 32'h3);
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic write1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
        int n;
        awid = 4'h3; awaddr = a; awlen = 4'd0; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        check("aw_ready", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        write_tail(d, s, er);
    endtask

    task automatic read_burst(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic [1:0] er, input bit tog);
        logic [31:0] e [4];
        int n, beat;
        bit r;
        e = '{e0, e1, e2, e3};
        arid = 4'h9; araddr = a; arlen = len; arburst = bu; arsize = 3'd2; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        check("ar_ready", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        n = 1;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        check("r_latency", 32'(n), 32'd3);
        beat = 0;
        r = 1'b1;
        while (beat <= int'(len) && n < 60) begin
            if (rvalid) begin
                check("r_data", rdata, e[beat]);
                check("r_resp", 32'(rresp), 32'(er));
                check("r_last", 32'(rlast), 32'(beat == int'(len)));
                check("r_id", 32'(rid), 32'h9);
                rready = r;
                if (r) beat++;
                if (tog) r = !r;
            end else rready = 1'b0;
            @(negedge clk);
            n++;
        end
        rready = 1'b0;
        check("r_beats", 32'(beat), 32'(len) + 32'd1);
        check("r_done", 32'(rvalid), 32'd0);
    endtask

    initial begin
        int n;
        bit rd_done, seen_b;
        tbl[0]  = '{1'b1, 32'h1fc00010, 32'h12345678, 4'hf, 2'b00};
        tbl[1]  = '{1'b0, 32'h1fc00010, 32'h12345678, 4'h0, 2'b00};
        tbl[2]  = '{1'b1, 32'h1fc00020, 32'hffffffff, 4'hf, 2'b00};
        tbl[3]  = '{1'b1, 32'h1fc00020, 32'h000000aa, 4'h1, 2'b00};
        tbl[4]  = '{1'b0, 32'h1fc00020, 32'hffffffaa, 4'h0, 2'b00};
        tbl[5]  = '{1'b1, 32'h1fc00000, 32'ha0a0a0a0, 4'hf, 2'b00};
        tbl[6]  = '{1'b1, 32'h1fc00004, 32'ha1a1a1a1, 4'hf, 2'b00};
        tbl[7]  = '{1'b1, 32'h1fc00008, 32'ha2a2a2a2, 4'hf, 2'b00};
        tbl[8]  = '{1'b1, 32'h1fc0000c, 32'ha3a3a3a3, 4'hf, 2'b00};
        tbl[9]  = '{1'b1, 32'h1fc00024, 32'h11223344, 4'hf, 2'b00};
        tbl[10] = '{1'b1, 32'h1fc00024, 32'h55660000, 4'hc, 2'b00};
        tbl[11] = '{1'b0, 32'h1fc00024, 32'h55663344, 4'h0, 2'b00};
        tbl[12] = '{1'b1, 32'h1fc04010, 32'hdeadbeef, 4'hf, DE ? 2'b11 : 2'b00};
        tbl[13] = '{1'b0, 32'h1fc00010, DE ? 32'h12345678 : 32'hdeadbeef, 4'h0, 2'b00};
        tbl[14] = '{1'b0, 32'h00000000, DE ? 32'h0 : 32'ha0a0a0a0, 4'h0, DE ? 2'b11 : 2'b00};
        tbl[15] = '{1'b1, 32'h1fc00024, 32'hffffffff, 4'h0, 2'b00};
        tbl[16] = '{1'b0, 32'h1fc00024, 32'h55663344, 4'h0, 2'b00};

        rst = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_arready", 32'(arready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].wr) write1(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp);
            else read_burst(tbl[i].addr, 8'd0, 2'b01, tbl[i].data, 32'd0, 32'd0, 32'd0, tbl[i].resp, 1'b0);
        end

        read_burst(32'h1fc00000, 8'd3, 2'b01, 32'ha0a0a0a0, 32'ha1a1a1a1, 32'ha2a2a2a2, 32'ha3a3a3a3, 2'b00, 1'b1);
        read_burst(32'h1fc00008, 8'd1, 2'b00, 32'ha2a2a2a2, 32'ha2a2a2a2, 32'd0, 32'd0, 2'b00, 1'b0);

        arid = 4'h9; araddr = 32'h1fc00000; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
        awid = 4'h3; awaddr = 32'h1fc00050; awlen = 4'd0; awburst = 2'b01; awvalid = 1'b1;
        #1;
        check("prio_arready", 32'(arready), 32'd1);
        check("prio_awready", 32'(awready), 32'd0);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1; rd_done = 1'b0;
        n = 0;
        while (!awready && n < 30) begin
            if (rvalid && rlast) rd_done = 1'b1;
            @(negedge clk);
            n++;
        end
        rready = 1'b0;
        check("prio_read_first", 32'(rd_done), 32'd1);
        check("prio_aw_later", 32'(awready), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        write_tail(32'h5a5a5a5a, 4'hf, 2'b00);
        read_burst(32'h1fc00050, 8'd0, 2'b01, 32'h5a5a5a5a, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0);

        for (int i = 0; i < 4; i++) write1(32'h1fc00040 + 32'(4 * i), 32'hc0c0c0c0 + 32'(i), 4'hf, 2'b00);
        awid = 4'h3; awaddr = 32'h1fc00040; awlen = 4'd3; awburst = 2'b01; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wdata = 32'hd0d0d0d0 + 32'(b); wstrb = 4'hf; wvalid = 1'b1;
            n = 0;
            while (!wready && n < 20) begin @(negedge clk); n++; end
            @(negedge clk);
        end
        wvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_outs", outs(), 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        bready = 1'b1;
        seen_b = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bvalid) seen_b = 1'b1;
        end
        bready = 1'b0;
        check("rst_no_bvalid", 32'(seen_b), 32'd0);
        read_burst(32'h1fc00040, 8'd3, 2'b01, 32'hd0d0d0d0, 32'hd0d0d0d1, 32'hc0c0c0c2, 32'hc0c0c0c3, 2'b00, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
